// File: rtl/mega_joy_scanner.sv
// mega_joy_scanner: DB9 pad scanner for Atari, 3-button MD and 6-button MD pads.
// Drives the shared select line and commits one button word per port per scan.
module mega_joy_scanner #(
  parameter int NUM_PORTS  = 2,
  parameter int TICK_DIV   = 768,
  parameter int IDLE_TICKS = 32,
  parameter int SIX_BTN_EN = 1
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic [6*NUM_PORTS-1:0]  joy_i,
  output logic                    joy_sel_o,
  output logic [12*NUM_PORTS-1:0] joy_o,
  output logic [NUM_PORTS-1:0]    is_md_o,
  output logic [NUM_PORTS-1:0]    is_six_o,
  output logic                    frame_o
);

  localparam int DW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int IW = (IDLE_TICKS > 2) ? $clog2(IDLE_TICKS) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
  localparam int IDLE_M1 = (IDLE_TICKS > 0) ? IDLE_TICKS - 1 : 0;
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_M1);
  localparam logic SIX_EN = (SIX_BTN_EN != 0);

  typedef enum logic [3:0] {
    P0, P1, P2, P3, P4, P5, P6, P7, IDLE
  } phase_t;

  logic [6*NUM_PORTS-1:0]  r_sync1;
  logic [6*NUM_PORTS-1:0]  r_sync2;
  logic [DW-1:0]           r_div;
  logic [IW-1:0]           r_idle;
  phase_t                  r_phase;
  logic [12*NUM_PORTS-1:0] r_wk;
  logic [NUM_PORTS-1:0]    r_md;
  logic [NUM_PORTS-1:0]    r_six;

  phase_t     w_next;
  logic       w_sel_next;
  logic       w_last;
  logic [5:0] w_pin [NUM_PORTS];

  assign w_last = (r_div == DIV_LAST);

  always_comb begin
    w_next = P0;
    case (r_phase)
      P0:      w_next = P1;
      P1:      w_next = P2;
      P2:      w_next = P3;
      P3:      w_next = P4;
      P4:      w_next = P5;
      P5:      w_next = P6;
      P6:      w_next = P7;
      P7:      w_next = (IDLE_TICKS == 0) ? P0 : IDLE;
      IDLE:    w_next = (r_idle == IDLE_LAST) ? P0 : IDLE;
      default: w_next = P0;
    endcase
  end

  // Select is low only in the three MD probe phases.
  always_comb begin
    w_sel_next = 1'b1;
    if (w_next == P1 || w_next == P3 || w_next == P5)
      w_sel_next = 1'b0;
  end

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++)
      w_pin[p] = r_sync2[6*p +: 6];
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= joy_i;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_div     <= '0;
      r_idle    <= '0;
      r_phase   <= P0;
      r_wk      <= '0;
      r_md      <= '0;
      r_six     <= '0;
      joy_sel_o <= 1'b1;
      joy_o     <= '0;
      is_md_o   <= '0;
      is_six_o  <= '0;
      frame_o   <= 1'b0;
    end else if (!w_last) begin
      r_div   <= r_div + 1'b1;
      frame_o <= 1'b0;
    end else begin
      r_div     <= '0;
      r_phase   <= w_next;
      joy_sel_o <= w_sel_next;
      frame_o   <= (r_phase == P7);
      if (r_phase == IDLE)
        r_idle <= r_idle + 1'b1;
      else
        r_idle <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        case (r_phase)
          P0: r_wk[12*p +: 6] <= ~w_pin[p];
          P1: begin
            if (w_pin[p][3:2] == 2'b00) begin
              r_md[p]           <= 1'b1;
              r_wk[12*p+6 +: 2] <= ~w_pin[p][5:4];
            end else begin
              r_md[p]           <= 1'b0;
              r_wk[12*p+6 +: 2] <= 2'b00;
            end
          end
          P5: r_six[p] <= r_md[p] & SIX_EN &
                          (w_pin[p][3:0] == 4'h0);
          P6: begin
            if (r_six[p])
              r_wk[12*p+8 +: 4] <= ~w_pin[p][3:0];
            else
              r_wk[12*p+8 +: 4] <= 4'h0;
          end
          P7: begin
            joy_o[12*p +: 12] <= r_wk[12*p +: 12];
            is_md_o[p]        <= r_md[p];
            is_six_o[p]       <= r_six[p];
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mega_joy_scanner.sv
// Scoreboard bench for mega_joy_scanner with pad models and random pads.
// Two DUTs share the pins: one with 6-button decode enabled, one without.
module tb_mega_joy_scanner;

  localparam int NP = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [11:0]   joy_i;
  logic          sel_a, sel_b;
  logic [23:0]   joy_a, joy_b;
  logic [1:0]    md_a, md_b, six_a, six_b;
  logic          fr_a, fr_b;

  always #5 clk = ~clk;

  mega_joy_scanner #(
    .NUM_PORTS(NP), .TICK_DIV(4), .IDLE_TICKS(2), .SIX_BTN_EN(1)
  ) u_dut (
    .clk_sys(clk), .reset(rst), .joy_i(joy_i),
    .joy_sel_o(sel_a), .joy_o(joy_a), .is_md_o(md_a),
    .is_six_o(six_a), .frame_o(fr_a)
  );

  mega_joy_scanner #(
    .NUM_PORTS(NP), .TICK_DIV(4), .IDLE_TICKS(2), .SIX_BTN_EN(0)
  ) u_dut_n (
    .clk_sys(clk), .reset(rst), .joy_i(joy_i),
    .joy_sel_o(sel_b), .joy_o(joy_b), .is_md_o(md_b),
    .is_six_o(six_b), .frame_o(fr_b)
  );

  // kind: 0 unplugged, 1 Atari, 2 MD 3-button, 3 MD 6-button
  // btn bits follow the output word {Mode,X,Y,Z,St,A,C,B,R,L,D,U}
  typedef struct {
    int          kind;
    logic [11:0] btn;
  } pad_t;

  typedef struct {
    logic [23:0] j_en;
    logic [23:0] j_dis;
    logic [1:0]  md;
    logic [1:0]  six;
  } exp_t;

  pad_t pads [NP];
  exp_t sb [$];
  int   n_vec = 0;
  int   n_err = 0;

  // Pad-side select edge counter; a long high stretch resets it
  int   pcnt;
  int   phi;
  logic psel;

  always @(negedge clk) begin
    if (rst) begin
      pcnt <= 0;
      phi  <= 0;
      psel <= 1'b1;
    end else begin
      psel <= sel_a;
      phi  <= sel_a ? phi + 1 : 0;
      if (sel_a && phi >= 9)
        pcnt <= 0;
      else if (psel && !sel_a)
        pcnt <= pcnt + 1;
    end
  end

  function automatic logic [5:0] pad_pins(
    int kind, logic [11:0] b, logic sel, int cnt);
    logic [5:0] md_lo;
    md_lo = {~b[7], ~b[6], 2'b00, ~b[1], ~b[0]};
    case (kind)
      1: return ~b[5:0];
      2: return sel ? ~b[5:0] : md_lo;
      3: begin
        if (cnt == 3)
          return sel ? {~b[5], ~b[4], ~b[11:8]}
                     : {~b[7], ~b[6], 4'b0000};
        return sel ? ~b[5:0] : md_lo;
      end
      default: return 6'h3F;
    endcase
  endfunction

  assign joy_i = {
    pad_pins(pads[1].kind, pads[1].btn, sel_a, pcnt),
    pad_pins(pads[0].kind, pads[0].btn, sel_a, pcnt)
  };

  function automatic logic [11:0] exp_word(
    int kind, logic [11:0] b, bit six_en);
    case (kind)
      1: return b & 12'h03F;
      2: return b & 12'h0FF;
      3: return six_en ? b : (b & 12'h0FF);
      default: return 12'h000;
    endcase
  endfunction

  task automatic push_exp();
    exp_t e;
    for (int p = 0; p < NP; p++) begin
      e.j_en[12*p +: 12]  = exp_word(pads[p].kind, pads[p].btn, 1'b1);
      e.j_dis[12*p +: 12] = exp_word(pads[p].kind, pads[p].btn, 1'b0);
      e.md[p]  = (pads[p].kind >= 2);
      e.six[p] = (pads[p].kind == 3);
    end
    sb.push_back(e);
  endtask

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] rnd_btn();
    logic [31:0] r;
    r = $urandom;
    if (r[0] && r[1]) r[1] = 1'b0;
    if (r[2] && r[3]) r[3] = 1'b0;
    return r[11:0];
  endfunction

  task automatic wait_frame();
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (fr_a) return;
    end
    chk("frame_timeout", 64'd0, 64'd1);
  endtask

  task automatic set_pad(int p, int kind, logic [11:0] b);
    pads[p].kind = kind;
    pads[p].btn  = b;
  endtask

  // Monitor: phase/sel/frame timing, reset values, scoreboard pops
  logic [55:0] prev;
  logic [55:0] cur;
  int          cyc;
  logic        e_sel;
  logic        e_fr;
  exp_t        e;

  initial begin
    cyc  = 0;
    prev = '0;
    forever begin
      @(negedge clk);
      cur = {joy_a, md_a, six_a, joy_b, md_b, six_b};
      if (rst) begin
        chk("reset_a", {joy_a, md_a, six_a, fr_a, sel_a}, 64'd1);
        chk("reset_b", {joy_b, md_b, six_b, fr_b, sel_b}, 64'd1);
        cyc = 0;
      end else begin
        e_sel = !(((cyc / 4) % 10) inside {1, 3, 5});
        e_fr  = ((cyc % 40) == 32);
        chk("sel", {sel_a, sel_b}, {e_sel, e_sel});
        chk("frame", {fr_a, fr_b}, {e_fr, e_fr});
        if (fr_a) begin
          if (sb.size() == 0) begin
            chk("sb_empty", 64'd0, 64'd1);
          end else begin
            e = sb.pop_front();
            chk("joy_en", joy_a, e.j_en);
            chk("md_en", md_a, e.md);
            chk("six_en", six_a, e.six);
            chk("joy_dis", joy_b, e.j_dis);
            chk("md_dis", md_b, e.md);
            chk("six_dis", six_b, 2'b00);
          end
        end else begin
          chk("hold", cur, prev);
        end
        cyc++;
      end
      prev = cur;
    end
  end

  initial begin
    rst = 1'b1;
    set_pad(0, 0, 12'h000);
    set_pad(1, 0, 12'h000);
    push_exp();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Atari: up + p6
    wait_frame();
    set_pad(0, 1, 12'h011);
    push_exp();

    // 3-button: A + Start + right
    wait_frame();
    set_pad(0, 0, 12'h000);
    set_pad(1, 2, 12'h0C8);
    push_exp();

    // 6-button: Mode + Y
    wait_frame();
    set_pad(0, 3, 12'hA00);
    push_exp();

    // Atari pins change in P3 of a scan; P0 value must commit
    wait_frame();
    set_pad(0, 1, 12'h011);
    push_exp();
    wait_frame();
    push_exp();
    repeat (20) @(posedge clk);
    #1 set_pad(0, 1, 12'h024);

    // Reset during P5, no commit of the partial scan
    wait_frame();
    set_pad(0, 1, 12'h006);
    set_pad(1, 0, 12'h000);
    push_exp();
    repeat (28) @(posedge clk);
    #1 rst = 1'b1;
    sb.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    push_exp();

    repeat (60) begin
      wait_frame();
      for (int p = 0; p < NP; p++)
        set_pad(p, int'($urandom_range(0, 3)), rnd_btn());
      push_exp();
    end
    wait_frame();
    repeat (4) @(posedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
